// File: rtl/exmm_stage.sv
// EX/MEM pipeline register with integrated dcache access controller.
// Holds one entry, issues its load/store until dhit, and freezes upstream meanwhile.
module exmm_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_memren,
  input  logic              ex_memwen,
  input  logic              ex_regwen,
  input  logic [1:0]        ex_memtoreg,
  input  logic              ex_halt,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [WORD_W-1:0] ex_aluout,
  input  logic [WORD_W-1:0] ex_store,
  input  logic [WORD_W-1:0] ex_npc,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              stall,
  output logic              mm_valid,
  output logic              mm_regwen,
  output logic [1:0]        mm_memtoreg,
  output logic              mm_halt,
  output logic [REG_W-1:0]  mm_rd,
  output logic [WORD_W-1:0] mm_aluout,
  output logic [WORD_W-1:0] mm_npc,
  output logic [WORD_W-1:0] mm_load,
  output logic              misalign,
  output logic              halt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                valid_q, regwen_q, memren_q, memwen_q, ehalt_q;
  logic [1:0]          memtoreg_q;
  logic [REG_W-1:0]    rd_q;
  logic [WORD_W-1:0]   aluout_q, store_q, npc_q, load_q;
  logic                misalign_q, halt_q;

  logic                in_access;
  logic                adv, latch;
  logic                new_valid, new_access, new_misalign;

  assign in_access    = (state_q == ACCESS);
  assign stall        = in_access & ~dhit;
  assign adv          = ihit & ~stall & ~halt_q;
  // An outstanding access owns the entry: a zero-wait dhit completes into DONE
  // rather than being overwritten by a same-edge advance.
  assign latch        = adv & ~in_access;
  assign new_valid    = ex_valid & ~flush;
  assign new_access   = new_valid & (ex_memren | ex_memwen) & ~ex_halt;
  assign new_misalign = new_access & (ex_aluout[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCESS:  if (dhit) state_d = DONE;
      default: if (latch) state_d = (new_access & ~new_misalign) ? ACCESS : IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q    <= 1'b0;
      regwen_q   <= 1'b0;
      memren_q   <= 1'b0;
      memwen_q   <= 1'b0;
      ehalt_q    <= 1'b0;
      memtoreg_q <= '0;
      rd_q       <= '0;
      aluout_q   <= '0;
      store_q    <= '0;
      npc_q      <= '0;
      load_q     <= '0;
      misalign_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      if (latch) begin
        valid_q    <= new_valid;
        regwen_q   <= new_valid & ex_regwen & ~new_misalign;
        memren_q   <= new_valid & ex_memren;
        memwen_q   <= new_valid & ex_memwen;
        ehalt_q    <= new_valid & ex_halt;
        memtoreg_q <= new_valid ? ex_memtoreg : '0;
        rd_q       <= new_valid ? ex_rd       : '0;
        aluout_q   <= new_valid ? ex_aluout   : '0;
        store_q    <= new_valid ? ex_store    : '0;
        npc_q      <= new_valid ? ex_npc      : '0;
        misalign_q <= misalign_q | new_misalign;
        halt_q     <= halt_q | (new_valid & ex_halt);
      end
      if (in_access && dhit && memren_q) load_q <= dmemload;
    end
  end

  assign dmemREN     = in_access & memren_q;
  assign dmemWEN     = in_access & memwen_q;
  assign dmemaddr    = in_access ? aluout_q : '0;
  assign dmemstore   = in_access ? store_q  : '0;

  assign mm_valid    = valid_q;
  assign mm_regwen   = regwen_q;
  assign mm_memtoreg = memtoreg_q;
  assign mm_halt     = ehalt_q;
  assign mm_rd       = rd_q;
  assign mm_aluout   = aluout_q;
  assign mm_npc      = npc_q;
  assign mm_load     = load_q;
  assign misalign    = misalign_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_exmm_stage.sv
// Randomized bench for exmm_stage against a transaction-level model,
// plus directed scenarios with literal expectations.
`timescale 1ns/100ps
module tb_exmm_stage;
  localparam int W = 32;
  localparam int R = 5;

  logic          CLK = 1'b0, nRST = 1'b0;
  logic          ihit = 0, flush = 0, ex_valid = 0, ex_memren = 0, ex_memwen = 0;
  logic          ex_regwen = 0, ex_halt = 0, dhit = 0;
  logic [1:0]    ex_memtoreg = '0;
  logic [R-1:0]  ex_rd = '0;
  logic [W-1:0]  ex_aluout = '0, ex_store = '0, ex_npc = '0, dmemload = '0;
  logic          dmemREN, dmemWEN, stall, mm_valid, mm_regwen, mm_halt, misalign, halt;
  logic [1:0]    mm_memtoreg;
  logic [R-1:0]  mm_rd;
  logic [W-1:0]  dmemaddr, dmemstore, mm_aluout, mm_npc, mm_load;

  always #5 CLK = ~CLK;

  exmm_stage #(.WORD_W(W), .REG_W(R)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush), .ex_valid(ex_valid),
    .ex_memren(ex_memren), .ex_memwen(ex_memwen), .ex_regwen(ex_regwen),
    .ex_memtoreg(ex_memtoreg), .ex_halt(ex_halt), .ex_rd(ex_rd),
    .ex_aluout(ex_aluout), .ex_store(ex_store), .ex_npc(ex_npc),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .stall(stall),
    .mm_valid(mm_valid), .mm_regwen(mm_regwen), .mm_memtoreg(mm_memtoreg),
    .mm_halt(mm_halt), .mm_rd(mm_rd), .mm_aluout(mm_aluout), .mm_npc(mm_npc),
    .mm_load(mm_load), .misalign(misalign), .halt(halt)
  );

  int vectors = 0;
  int errors  = 0;
  bit run     = 0;

  // Model: the held instruction, whether its memory request is still pending,
  // and the sticky flags.
  typedef struct {
    bit         valid, regwen, memren, memwen, hlt;
    bit [1:0]   mtr;
    bit [R-1:0] rd;
    bit [W-1:0] alu, st, npc;
  } ent_t;

  ent_t       m_e;
  bit         m_pending, m_halted, m_mis;
  bit [W-1:0] m_load;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_e = '{default: 0};
      m_pending = 0; m_halted = 0; m_mis = 0; m_load = '0;
    end else if (m_pending) begin
      if (dhit) begin
        if (m_e.memren) m_load = dmemload;
        m_pending = 0;
      end
    end else if (ihit && !m_halted) begin
      if (!ex_valid || flush) begin
        m_e = '{default: 0};
      end else begin
        m_e.valid = 1; m_e.regwen = ex_regwen; m_e.memren = ex_memren;
        m_e.memwen = ex_memwen; m_e.hlt = ex_halt; m_e.mtr = ex_memtoreg;
        m_e.rd = ex_rd; m_e.alu = ex_aluout; m_e.st = ex_store; m_e.npc = ex_npc;
        if (ex_halt) m_halted = 1;
        if ((ex_memren || ex_memwen) && !ex_halt) begin
          if (ex_aluout % 4 != 0) begin
            m_mis = 1;
            m_e.regwen = 0;
          end else begin
            m_pending = 1;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (run) begin
      logic [174:0] got, exp;
      #2;
      got = {dmemREN, dmemWEN, dmemaddr, dmemstore, stall, mm_valid, mm_regwen,
             mm_memtoreg, mm_halt, mm_rd, mm_aluout, mm_npc, mm_load, misalign, halt};
      exp = {m_pending & m_e.memren, m_pending & m_e.memwen,
             m_pending ? m_e.alu : 32'h0, m_pending ? m_e.st : 32'h0,
             m_pending & ~dhit, m_e.valid, m_e.regwen, m_e.mtr, m_e.hlt, m_e.rd,
             m_e.alu, m_e.npc, m_load, m_mis, m_halted};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL outputs @%0t: got %h want %h", $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_ex(input bit v, input bit ren, input bit wen, input bit rw,
                        input bit h, input logic [R-1:0] rd,
                        input logic [W-1:0] alu, input logic [W-1:0] st);
    ex_valid = v; ex_memren = ren; ex_memwen = wen; ex_regwen = rw; ex_halt = h;
    ex_rd = rd; ex_aluout = alu; ex_store = st; ex_npc = alu + 32'd4;
    ex_memtoreg = ren ? 2'd1 : 2'd0;
  endtask

  task automatic bubble();
    set_ex(0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge CLK); nRST = 0; bubble(); ihit = 0; dhit = 0; flush = 0;
    @(negedge CLK); @(negedge CLK); nRST = 1;
  endtask

  initial begin
    do_reset();
    run = 1;
    #3 chk("reset_mm_valid", {31'h0, mm_valid}, 32'h0);
    chk("reset_mm_load", mm_load, 32'h0);

    // Load with 3-cycle dhit latency
    @(negedge CLK); ihit = 1; dhit = 0; dmemload = 32'hDEADBEEF; set_ex(1, 1, 0, 1, 0, 5'd2, 32'h40, 32'h0);
    @(negedge CLK); bubble();
    #3 chk("ld_ren_c1", {31'h0, dmemREN}, 32'h1); chk("ld_stall_c1", {31'h0, stall}, 32'h1);
    chk("ld_addr", dmemaddr, 32'h40);
    @(negedge CLK);
    #3 chk("ld_ren_c2", {31'h0, dmemREN}, 32'h1); chk("ld_stall_c2", {31'h0, stall}, 32'h1);
    @(negedge CLK); dhit = 1;
    #3 chk("ld_ren_c3", {31'h0, dmemREN}, 32'h1); chk("ld_stall_c3", {31'h0, stall}, 32'h0);
    @(negedge CLK); dhit = 0;
    #3 chk("ld_ren_drop", {31'h0, dmemREN}, 32'h0); chk("ld_data", mm_load, 32'hDEADBEEF);

    // Zero-wait store
    @(negedge CLK); set_ex(1, 0, 1, 0, 0, '0, 32'h80, 32'h12345678);
    @(negedge CLK); bubble(); dhit = 1;
    #3 chk("st_wen", {31'h0, dmemWEN}, 32'h1); chk("st_stall", {31'h0, stall}, 32'h0);
    chk("st_addr", dmemaddr, 32'h80); chk("st_data", dmemstore, 32'h12345678);
    @(negedge CLK); dhit = 0;
    #3 chk("st_wen_drop", {31'h0, dmemWEN}, 32'h0); chk("st_load_kept", mm_load, 32'hDEADBEEF);

    // Flush on advance, then an ALU entry passes through
    @(negedge CLK); flush = 1; set_ex(1, 1, 0, 1, 0, 5'd9, 32'h100, 32'h0);
    @(negedge CLK); flush = 0; set_ex(1, 0, 0, 1, 0, 5'd5, 32'h7, 32'h0);
    #3 chk("fl_valid", {31'h0, mm_valid}, 32'h0); chk("fl_ren", {31'h0, dmemREN}, 32'h0);
    @(negedge CLK); bubble();
    #3 chk("alu_valid", {31'h0, mm_valid}, 32'h1); chk("alu_regwen", {31'h0, mm_regwen}, 32'h1);
    chk("alu_rd", {27'h0, mm_rd}, 32'h5); chk("alu_out", mm_aluout, 32'h7);

    // Misaligned load
    @(negedge CLK); set_ex(1, 1, 0, 1, 0, 5'd4, 32'h42, 32'h0);
    @(negedge CLK); set_ex(1, 0, 0, 1, 0, 5'd3, 32'h11, 32'h0);
    #3 chk("mis_flag", {31'h0, misalign}, 32'h1); chk("mis_ren", {31'h0, dmemREN}, 32'h0);
    chk("mis_regwen", {31'h0, mm_regwen}, 32'h0); chk("mis_valid", {31'h0, mm_valid}, 32'h1);
    @(negedge CLK); bubble();
    #3 chk("mis_continue_rd", {27'h0, mm_rd}, 32'h3);

    // Reset mid-access
    @(negedge CLK); set_ex(1, 1, 0, 1, 0, 5'd1, 32'h100, 32'h0);
    @(negedge CLK); bubble();
    #3 chk("rst_pre_ren", {31'h0, dmemREN}, 32'h1);
    @(negedge CLK); #1 nRST = 0;
    #2 chk("rst_ren_now", {31'h0, dmemREN}, 32'h0); chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_aluout", mm_aluout, 32'h0);
    @(negedge CLK); nRST = 1;
    #3 chk("rst_load", mm_load, 32'h0); chk("rst_ren_after", {31'h0, dmemREN}, 32'h0);

    // HALT freezes the stage
    @(negedge CLK); set_ex(1, 0, 0, 0, 1, 5'd0, 32'h55, 32'h0);
    @(negedge CLK); set_ex(1, 1, 0, 1, 0, 5'd6, 32'h40, 32'h0);
    #3 chk("halt_flag", {31'h0, halt}, 32'h1); chk("halt_mm", {31'h0, mm_halt}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); dhit = i[0];
      #3 chk("halt_no_req", {31'h0, dmemREN}, 32'h0); chk("halt_frozen", mm_aluout, 32'h55);
    end

    // Randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        int unsigned op;
        logic [W-1:0] a;
        @(negedge CLK);
        op = $urandom_range(0, 3);
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        ihit  = ($urandom_range(0, 3) != 0);
        dhit  = ($urandom_range(0, 2) == 0);
        flush = ($urandom_range(0, 7) == 0);
        dmemload = $urandom;
        set_ex($urandom_range(0, 5) != 0, op == 1, op == 2, $urandom_range(0, 1) == 1,
               $urandom_range(0, 149) == 0, R'($urandom), a, $urandom);
        ex_npc = $urandom;
      end
    end

    @(negedge CLK);
    #4 run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
